// File: rtl/iiitb_uart_rx.sv
// UART receiver, 8N1, LSB first, with 16x oversampling and four selectable rates.
//
// Ports:
//   clk        system clock, everything runs on its rising edge
//   reset      synchronous, active-high reset
//   rx         asynchronous serial line, idle high
//   baud_sel   rate select: 0=115200, 1=38400, 2=19200, 3=9600
//   data_out   last correctly framed byte
//   data_valid one-cycle pulse when data_out is updated
//   frame_err  one-cycle pulse when the stop bit samples low
//   busy       high whenever a frame is being received
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | timing to mid start bit to reject glitches
// DATA  | sampling the 8 data bits at their centres
// STOP  | sampling the stop bit, then reporting the outcome
module iiitb_uart_rx #(
  parameter int OS_DIV_1152 = 68,
  parameter int OS_DIV_384  = 203,
  parameter int OS_DIV_192  = 407,
  parameter int OS_DIV_96   = 814
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic [1:0] baud_sel,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_n;
  logic        rx_meta, rxs;
  logic        armed;
  logic [1:0]  baud_lat;
  logic [15:0] div_cnt, div_last;
  logic        tick;
  logic [3:0]  tick_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        start_det, start_smp, bit_smp, stop_smp;

  always_comb begin
    div_last = 16'(OS_DIV_1152 - 1);
    case (baud_lat)
      2'd0: div_last = 16'(OS_DIV_1152 - 1);
      2'd1: div_last = 16'(OS_DIV_384 - 1);
      2'd2: div_last = 16'(OS_DIV_192 - 1);
      2'd3: div_last = 16'(OS_DIV_96 - 1);
      default: div_last = 16'(OS_DIV_1152 - 1);
    endcase
  end

  assign tick = (div_cnt == div_last);

  // armed means the line has been seen high since reset, the last start edge,
  // or the end of the last frame; a line stuck low never looks like a start.
  assign start_det = (state == IDLE) && !rxs && armed;
  assign start_smp = (state == START) && tick && (tick_cnt == 4'd7);
  assign bit_smp   = (state == DATA) && tick && (tick_cnt == 4'd15);
  assign stop_smp  = (state == STOP) && tick && (tick_cnt == 4'd15);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start_det) state_n = START;
      START: if (start_smp) state_n = rxs ? IDLE : DATA;
      DATA:  if (bit_smp && (bit_cnt == 3'd7)) state_n = STOP;
      STOP:  if (stop_smp) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      armed      <= 1'b0;
      baud_lat   <= 2'd0;
      div_cnt    <= 16'd0;
      tick_cnt   <= 4'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rxs        <= rx_meta;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (start_det)     armed <= 1'b0;
      else if (stop_smp) armed <= rxs;
      else if (rxs)      armed <= 1'b1;

      if (start_det) begin
        div_cnt  <= 16'd0;
        tick_cnt <= 4'd0;
        bit_cnt  <= 3'd0;
        baud_lat <= baud_sel;
      end else begin
        div_cnt <= tick ? 16'd0 : div_cnt + 16'd1;
        // tick_cnt wraps 15->0 on its own, which re-aligns DATA and STOP
        if (start_smp)                     tick_cnt <= 4'd0;
        else if (tick && (state != IDLE))  tick_cnt <= tick_cnt + 4'd1;
        if (bit_smp) begin
          shift   <= {rxs, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (stop_smp) begin
          if (rxs) begin
            data_out   <= shift;
            data_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_iiitb_uart_rx.sv
// Randomized and directed bench for iiitb_uart_rx. A line driver serializes
// bytes and queues the expected outcome; a monitor pops and checks each pulse.
module tb_iiitb_uart_rx;

  localparam int D0 = 4;
  localparam int D1 = 6;
  localparam int D2 = 9;
  localparam int D3 = 13;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [1:0] baud_sel;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  iiitb_uart_rx #(
    .OS_DIV_1152(D0), .OS_DIV_384(D1), .OS_DIV_192(D2), .OS_DIV_96(D3)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .baud_sel(baud_sel),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         t0;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [7:0] last_good;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int div_of(input int r);
    case (r)
      0: return D0;
      1: return D1;
      2: return D2;
      default: return D3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line model: start bit, 8 bits LSB first, stop bit, each 16 oversample ticks.
  // The stop sample lands 9.5 bit periods after the falling edge, plus the
  // synchronizer and edge-detect cycles.
  task automatic send_frame(input logic [7:0] d, input int r, input logic stop);
    int   dv;
    exp_t e;
    dv = div_of(r);
    @(negedge clk);
    rx = 1'b0;
    e.t0 = cyc;
    e.lat = 152 * dv + 3;
    e.is_err = !stop;
    if (stop) begin
      e.data = d;
      last_good = d;
    end else begin
      e.data = last_good;
    end
    q.push_back(e);
    repeat (16 * dv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (16 * dv) @(negedge clk);
    end
    rx = stop;
    repeat (16 * dv) @(negedge clk);
    rx = 1'b1;
    repeat (16 * dv) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_data);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_data_out"}, 32'(data_out), 32'(exp_data));
    chk({tag, "_data_valid"}, 32'(data_valid), 32'd0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   delta;
    forever begin
      @(negedge clk);
      if (data_valid && frame_err)
        chk("pulse_exclusive", 32'd1, 32'd0);
      else if (data_valid || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, data_valid, frame_err}, 32'd0);
        end else begin
          e = q.pop_front();
          delta = cyc - e.t0;
          chk("outcome_is_err", 32'(frame_err), 32'(e.is_err));
          chk("data_out", 32'(data_out), 32'(e.data));
          if (delta < e.lat - 2 || delta > e.lat + 2)
            chk("latency", 32'(delta), 32'(e.lat));
          else
            n_checks++;
        end
      end
    end
  end

  initial begin
    int   r;
    logic [7:0] d;
    logic st;
    int   waited;

    reset = 1'b1;
    rx = 1'b1;
    baud_sel = 2'd0;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    baud_sel = 2'd0;
    send_frame(8'hA5, 0, 1'b1);
    check_idle_outputs("after_a5", 8'hA5);

    baud_sel = 2'd3;
    send_frame(8'h3C, 3, 1'b1);

    baud_sel = 2'd1;
    send_frame(8'h55, 1, 1'b0);
    check_idle_outputs("after_ferr", 8'h3C);

    // glitch: 4 ticks low, rejected at the mid start-bit check
    baud_sel = 2'd0;
    @(negedge clk);
    rx = 1'b0;
    repeat (4 * D0) @(negedge clk);
    rx = 1'b1;
    repeat (16 * D0) @(negedge clk);
    check_idle_outputs("after_glitch", 8'h3C);
    send_frame(8'h81, 0, 1'b1);

    // reset while the receiver waits to sample data bit 4
    baud_sel = 2'd1;
    @(negedge clk);
    rx = 1'b0;
    repeat (16 * D1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (16 * D1) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * D1) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx = 1'b1;
    last_good = 8'h00;
    check_idle_outputs("abort", 8'h00);
    repeat (16 * 16 * D1) @(negedge clk);
    check_idle_outputs("abort_quiet", 8'h00);
    send_frame(8'hFF, 1, 1'b1);

    // rate change mid-frame applies only to the following frame
    baud_sel = 2'd0;
    fork
      send_frame(8'h5A, 0, 1'b1);
      begin
        repeat (5 * 16 * D0) @(negedge clk);
        baud_sel = 2'd2;
      end
    join
    send_frame(8'hC3, 2, 1'b1);

    for (int i = 0; i < 12; i++) begin
      r  = int'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 5) != 0);
      baud_sel = 2'(r);
      send_frame(d, r, st);
    end

    waited = 0;
    while (q.size() != 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    repeat (8) @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
